// File: rtl/mod107_residue_accum_pkg.sv
// Shared constants and types for the mod-107 residue datapath
// (LUT-bank wrapper, accumulator and adder-tree stages).
package mod107_pkg;
  localparam int MODULUS    = 107;
  localparam int RES_W      = 7;
  localparam int NUM_CHUNKS = 84;
  localparam int CNT_W      = 7;

  typedef logic [RES_W-1:0] residue_t;
endpackage

// File: rtl/mod107_residue_accum_if.sv
// Partial-residue input stream and frame-residue output stream.
interface mod107_residue_accum_if #(
  parameter int RES_W = mod107_pkg::RES_W
);
  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_data;
  logic             out_err;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err, busy
  );
endinterface

// File: rtl/mod107_residue_accum_mod_add.sv
// Combinational modular add: reduces b once into range, then a + b mod MODULUS.
// a must already be in range; b_illegal flags an out-of-range b.
module mod_add
  import mod107_pkg::*;
#(
  parameter int MODULUS = mod107_pkg::MODULUS,
  parameter int RES_W   = mod107_pkg::RES_W
) (
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] sum,
  output logic             b_illegal
);
  localparam logic [RES_W-1:0] MOD_R = RES_W'(MODULUS);
  localparam logic [RES_W:0]   MOD_X = (RES_W+1)'(MODULUS);

  logic [RES_W-1:0] d;
  logic [RES_W:0]   s;

  // Inputs are below 2^RES_W < 2*MODULUS, so one subtraction suffices.
  assign b_illegal = (b >= MOD_R);
  assign d         = b_illegal ? (b - MOD_R) : b;
  assign s         = {1'b0, a} + {1'b0, d};
  assign sum       = (s >= MOD_X) ? RES_W'(s - MOD_X) : RES_W'(s);
endmodule

// File: rtl/mod107_residue_accum.sv
// Accumulates one partial residue per beat modulo MODULUS over a frame of
// NUM_CHUNKS beats and presents the frame residue on a valid/ready output.
module mod107_residue_accum
  import mod107_pkg::*;
#(
  parameter int MODULUS    = mod107_pkg::MODULUS,
  parameter int RES_W      = mod107_pkg::RES_W,
  parameter int NUM_CHUNKS = mod107_pkg::NUM_CHUNKS,
  parameter int CNT_W      = mod107_pkg::CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  mod107_residue_accum_if.slave  bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] sum;
  logic [RES_W-1:0] out_data_q;
  logic [CNT_W-1:0] cnt;
  logic             err_acc;
  logic             illegal;
  logic             out_valid_q;
  logic             out_err_q;
  logic             last_beat;
  logic             in_ready;
  logic             accept;

  mod_add #(
    .MODULUS (MODULUS),
    .RES_W   (RES_W)
  ) u_add (
    .a         (acc),
    .b         (bus.in_data),
    .sum       (sum),
    .b_illegal (illegal)
  );

  // Only the closing beat can collide with an unconsumed result.
  assign last_beat = (cnt == LAST);
  assign in_ready  = !(last_beat && out_valid_q && !bus.out_ready);
  assign accept    = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      err_acc     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        if (last_beat) begin
          out_data_q  <= sum;
          out_err_q   <= err_acc | illegal;
          out_valid_q <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
          err_acc     <= 1'b0;
        end else begin
          acc     <= sum;
          cnt     <= cnt + CNT_W'(1);
          err_acc <= err_acc | illegal;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.busy      = (cnt != '0);
endmodule

// File: tb/tb_mod107_residue_accum.sv
// Scoreboard bench: a 4-chunk instance for most scenarios plus a default
// 84-chunk instance for the full-length frame.
module tb_mod107_residue_accum;
  import mod107_pkg::*;

  typedef struct packed {
    logic [6:0] data;
    logic       err;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod107_residue_accum_if bus4 ();
  mod107_residue_accum_if bus84 ();

  mod107_residue_accum #(.NUM_CHUNKS(4), .CNT_W(3)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  mod107_residue_accum dut84 (
    .clk (clk),
    .rst (rst),
    .bus (bus84)
  );

  res_t q4[$];
  res_t q84[$];
  res_t e4, e84;
  int compared   = 0;
  int mismatched = 0;

  // Output monitors: a handshake seen after the falling edge completes on
  // the following rising edge.
  always @(negedge clk) begin
    #2;
    if (!rst && bus4.out_valid && bus4.out_ready) begin
      compared++;
      if (q4.size() == 0) begin
        mismatched++;
        $display("FAIL out4_unexpected: got data=%0d err=%0d, required no output",
                 bus4.out_data, bus4.out_err);
      end else begin
        e4 = q4.pop_front();
        if (bus4.out_data !== e4.data || bus4.out_err !== e4.err) begin
          mismatched++;
          $display("FAIL out4_result: got data=%0d err=%0d, required data=%0d err=%0d",
                   bus4.out_data, bus4.out_err, e4.data, e4.err);
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && bus84.out_valid && bus84.out_ready) begin
      compared++;
      if (q84.size() == 0) begin
        mismatched++;
        $display("FAIL out84_unexpected: got data=%0d err=%0d, required no output",
                 bus84.out_data, bus84.out_err);
      end else begin
        e84 = q84.pop_front();
        if (bus84.out_data !== e84.data || bus84.out_err !== e84.err) begin
          mismatched++;
          $display("FAIL out84_result: got data=%0d err=%0d, required data=%0d err=%0d",
                   bus84.out_data, bus84.out_err, e84.data, e84.err);
        end
      end
    end
  end

  // Presents one beat and returns just after the rising edge that accepts it.
  task automatic send(input int which, input logic [6:0] d);
    int n;
    n = 0;
    @(negedge clk);
    if (which == 4) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = d;
    end else begin
      bus84.in_valid = 1'b1;
      bus84.in_data  = d;
    end
    #1;
    while (((which == 4) ? !bus4.in_ready : !bus84.in_ready) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus4.in_valid  = 1'b0;
    bus84.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    compared++;
    if ({bus4.out_valid, bus4.out_data, bus4.out_err, bus4.busy, bus4.in_ready} !== 11'd1) begin
      mismatched++;
      $display("FAIL reset4: got v=%0b d=%0d e=%0b busy=%0b rdy=%0b, required 0 0 0 0 1",
               bus4.out_valid, bus4.out_data, bus4.out_err, bus4.busy, bus4.in_ready);
    end
    compared++;
    if ({bus84.out_valid, bus84.out_data, bus84.out_err, bus84.busy, bus84.in_ready} !== 11'd1) begin
      mismatched++;
      $display("FAIL reset84: got v=%0b d=%0d e=%0b busy=%0b rdy=%0b, required 0 0 0 0 1",
               bus84.out_valid, bus84.out_data, bus84.out_err, bus84.busy, bus84.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [6:0] vals    [4] = '{7'd100, 7'd50, 7'd7, 7'd106};
    logic [6:0] exp_acc [3] = '{7'd100, 7'd43, 7'd50};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) q4.push_back('{data: 7'd49, err: 1'b0});
      send(4, vals[i]);
      #1;
      compared++;
      if (i < 3) begin
        if (dut4.acc !== exp_acc[i] || bus4.out_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL basic_acc%0d: got acc=%0d v=%0b, required acc=%0d v=0",
                   i, dut4.acc, bus4.out_valid, exp_acc[i]);
        end
      end else if (bus4.out_valid !== 1'b1 || bus4.out_data !== 7'd49) begin
        mismatched++;
        $display("FAIL basic_latency: got v=%0b d=%0d, required v=1 d=49",
                 bus4.out_valid, bus4.out_data);
      end
    end
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_full84();
    for (int i = 0; i < 84; i++) begin
      if (i == 83) q84.push_back('{data: 7'd23, err: 1'b0});
      send(84, 7'd106);
      if (i == 0 || i == 83) begin
        #1;
        compared++;
        if (bus84.busy !== (i == 0)) begin
          mismatched++;
          $display("FAIL full84_busy%0d: got %0b, required %0b", i, bus84.busy, i == 0);
        end
      end
    end
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [6:0] f1 [4] = '{7'd120, 7'd0, 7'd0, 7'd0};
    q4.push_back('{data: 7'd13, err: 1'b1});
    q4.push_back('{data: 7'd4, err: 1'b0});
    for (int i = 0; i < 4; i++) begin
      send(4, f1[i]);
      if (i == 0) begin
        #1;
        compared++;
        if (dut4.acc !== 7'd13) begin
          mismatched++;
          $display("FAIL illegal_reduce: got acc=%0d, required 13", dut4.acc);
        end
      end
    end
    for (int i = 0; i < 4; i++) send(4, 7'd1);
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stall();
    @(negedge clk);
    bus4.out_ready = 1'b0;
    q4.push_back('{data: 7'd10, err: 1'b0});
    for (int i = 1; i <= 4; i++) send(4, 7'(i));
    for (int i = 5; i <= 7; i++) send(4, 7'(i));
    q4.push_back('{data: 7'd26, err: 1'b0});
    @(negedge clk);
    bus4.in_valid = 1'b1;
    bus4.in_data  = 7'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if (bus4.in_ready !== 1'b0 || bus4.out_valid !== 1'b1 || bus4.out_data !== 7'd10 ||
          bus4.busy !== 1'b1) begin
        mismatched++;
        $display("FAIL stall_hold%0d: got rdy=%0b v=%0b d=%0d busy=%0b, required 0 1 10 1",
                 i, bus4.in_ready, bus4.out_valid, bus4.out_data, bus4.busy);
      end
      @(negedge clk);
    end
    bus4.out_ready = 1'b1;
    #1;
    compared++;
    if (bus4.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_release: got in_ready=%0b, required 1", bus4.in_ready);
    end
    @(posedge clk);
    #1;
    compared++;
    if (bus4.out_valid !== 1'b1 || bus4.out_data !== 7'd26 || bus4.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_next: got v=%0b d=%0d busy=%0b, required 1 26 0",
               bus4.out_valid, bus4.out_data, bus4.busy);
    end
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    send(4, 7'd60);
    send(4, 7'd60);
    #1;
    compared++;
    if (bus4.busy !== 1'b1 || dut4.acc !== 7'd13) begin
      mismatched++;
      $display("FAIL midrst_pre: got busy=%0b acc=%0d, required 1 13", bus4.busy, dut4.acc);
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (dut4.acc !== 7'd0 || bus4.busy !== 1'b0 || bus4.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_clear: got acc=%0d busy=%0b v=%0b, required 0 0 0",
               dut4.acc, bus4.busy, bus4.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    q4.push_back('{data: 7'd20, err: 1'b0});
    for (int i = 0; i < 4; i++) send(4, 7'd5);
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          int   msum;
          logic merr;
          msum = 0;
          merr = 1'b0;
          for (int b = 0; b < 4; b++) begin
            logic [6:0] d;
            repeat ($urandom_range(0, 2)) idle();
            if ($urandom_range(0, 9) == 0) d = 7'($urandom_range(107, 127));
            else                           d = 7'($urandom_range(0, 106));
            if (d >= 7'd107) begin
              merr = 1'b1;
              msum = msum + int'(d) - 107;
            end else begin
              msum = msum + int'(d);
            end
            msum = msum % 107;
            if (b == 3) q4.push_back('{data: 7'(msum), err: merr});
            send(4, d);
          end
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          bus4.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus4.out_ready = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    bus4.in_valid   = 1'b0;
    bus4.in_data    = '0;
    bus4.out_ready  = 1'b1;
    bus84.in_valid  = 1'b0;
    bus84.in_data   = '0;
    bus84.out_ready = 1'b1;

    test_reset();
    test_basic();
    test_full84();
    test_illegal();
    test_stall();
    test_mid_reset();
    test_random();

    repeat (5) @(negedge clk);
    compared++;
    if (q4.size() != 0 || q84.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d/%0d results outstanding, required 0/0",
               q4.size(), q84.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
